rx_cmd_ctrl: RTL and testbench
==============================

// Module: rx_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receive path. Consumes the validated bytes
//  (RxData/RxValid) and decodes framed commands into register-file writes/reads
//  and ALU operations. Pushes the results into the TX FIFO, and gates the ALU
//  clock only while an ALU operation is in progress.
// PARAMETERS
//  DATA_W   8    byte/register width (RxData, RegWrData, TxData)
//  ADDR_W   4    register-file address width
//  WAIT_MAX 15   max cycles to wait for RegRdValid/AluValid before abort
// PORTS
//  CLK        in   1          system clock
//  RST        in   1          asynchronous, active-high reset
//  RxData     in   DATA_W     received byte from UART RX (parallel data)
//  RxValid    in   1          1-cycle pulse: RxData is a good frame
//  RegRdData  in   DATA_W     register-file read data
//  RegRdValid in   1          1-cycle pulse: RegRdData valid
//  AluOut     in   2*DATA_W   ALU result
//  AluValid   in   1          1-cycle pulse: AluOut valid
//  FifoFull   in   1          TX FIFO full
//  RegAddr    out  ADDR_W     register-file address
//  RegWrData  out  DATA_W     register-file write data
//  RegWrEn    out  1          1-cycle write strobe
//  RegRdEn    out  1          1-cycle read strobe
//  AluEn      out  1          1-cycle ALU start strobe
//  AluFun     out  4          ALU function code
//  ClkGateEn  out  1          ALU clock-gate enable
//  TxData     out  DATA_W     byte to TX FIFO
//  TxWrEn     out  1          1-cycle TX FIFO push
//  CmdErr     out  1          1-cycle pulse: unknown cmd, dropped byte or timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; internal address/result regs 0. RST
//    mid-command aborts the command immediately with no partial strobes.
//  - Commands, byte sequences on RxValid:
//    * 0xAA addr data: register write.
//    * 0xBB addr: register read.
//    * 0xCC A B fun: A is written to reg 0, B to reg 1, then the ALU is run.
//    * 0xDD fun: the ALU is run on the operands already in reg 0/1.
//  - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN,
//    ALU_WAIT, TX_LO, TX_HI.
//  - IDLE:
//    * 0xAA->WR_ADDR; 0xBB->RD_ADDR; 0xCC->OPA; 0xDD->ALU_FUN.
//    * Other byte: CmdErr pulse, stay IDLE.
//  - WR_ADDR: latch RxData[ADDR_W-1:0] ->WR_DATA.
//  - WR_DATA: next cycle RegWrEn=1 with RegAddr/RegWrData ->IDLE.
//  - RD_ADDR: latch addr; next cycle RegRdEn=1 ->RD_WAIT.
//  - RD_WAIT: RegRdValid captures RegRdData ->TX_LO (1-byte response).
//  - OPA/OPB: write the operand to addr 0 (OPA) or 1 (OPB), 1-cycle RegWrEn
//    each. Then OPA->OPB and OPB->ALU_FUN.
//  - ALU_FUN: latch AluFun=RxData[3:0]; ClkGateEn=1 from this cycle.
//    * AluEn pulses in the cycle after ClkGateEn first rises. ->ALU_WAIT.
//  - ALU_WAIT: AluValid captures AluOut; ClkGateEn drops the next cycle ->TX_LO.
//  - TX_LO: push the low byte (the read byte for reads).
//    * TxWrEn only when FifoFull=0; otherwise hold with TxData stable.
//    * ALU responses ->TX_HI; read responses ->IDLE.
//  - TX_HI: push the high byte, same FifoFull rule ->IDLE.
//  - Timeout: a wait counter is cleared on entering RD_WAIT/ALU_WAIT.
//    * When it reaches WAIT_MAX without a valid: CmdErr pulse ->IDLE, ClkGateEn=0.
//  - RxValid in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: the byte is dropped and
//    CmdErr pulses; the state is unaffected.
//  - Simultaneous RegRdValid/AluValid and timeout in the same cycle: valid wins.
//  - Strobes never overlap: RegWrEn, RegRdEn, AluEn and TxWrEn are mutually
//    exclusive each cycle.
// STRUCTURE
//  - Shared package: command opcodes (0xAA, 0xBB, 0xCC, 0xDD), state encoding,
//    operand register addresses (0, 1), ALU function width.
//  - One sub-module, ctrl_wait_timer: loadable up-counter with clear and a
//    terminal-count flag at WAIT_MAX.
//  - Rest: a single FSM with registered outputs.
// TESTING
//  - Write: AA,05,3C -> one RegWrEn with RegAddr=5, RegWrData=3C; then IDLE.
//  - Read: BB,05, RegRdValid with 3C -> RegRdEn once; one TxWrEn with TxData=3C.
//  - ALU: CC,07,03,00; AluOut=000A ->
//    * Regs: reg0=07, reg1=03.
//    * ALU: AluEn once; ClkGateEn high only ALU_FUN..ALU_WAIT.
//    * TX: TxData 0A then 00.
//  - Backpressure: FifoFull=1 for 5 cycles during TX_LO -> no TxWrEn; TxData
//    stable; push on the first non-full cycle.
//  - Errors:
//    * Opcode 0x55 -> CmdErr pulse, IDLE.
//    * DD,01 with no AluValid -> CmdErr after WAIT_MAX cycles, ClkGateEn=0.
//  - Reset: assert RST during WR_DATA -> no RegWrEn; all outputs 0.
//    * Next AA command after reset executes normally.

Source files
------------

// File: rtl/rx_cmd_ctrl_pkg.sv
// rtl/rx_cmd_ctrl_pkg.sv - shared opcodes, state encoding and constants for rx_cmd_ctrl
package rx_cmd_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU     = 8'hCC;
  localparam logic [7:0] OP_ALU_RUN = 8'hDD;

  localparam int REG_OPA   = 0;
  localparam int REG_OPB   = 1;
  localparam int ALU_FUN_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OPA,
    S_OPB,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_e;

endpackage

// File: rtl/rx_cmd_ctrl_wait_timer.sv
// rtl/rx_cmd_ctrl_wait_timer.sv - loadable up-counter with clear, saturating at a terminal count
module ctrl_wait_timer
  import rx_cmd_ctrl_pkg::*;
#(
  parameter int MAX   = 15,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(MAX));

  // Holds at MAX so a late valid cannot be mistaken for a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// rtl/rx_cmd_ctrl.sv - UART RX command sequencer driving register file, ALU and TX FIFO
module rx_cmd_ctrl
  import rx_cmd_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     RxData,
  input  logic                  RxValid,
  input  logic [DATA_W-1:0]     RegRdData,
  input  logic                  RegRdValid,
  input  logic [2*DATA_W-1:0]   AluOut,
  input  logic                  AluValid,
  input  logic                  FifoFull,
  output logic [ADDR_W-1:0]     RegAddr,
  output logic [DATA_W-1:0]     RegWrData,
  output logic                  RegWrEn,
  output logic                  RegRdEn,
  output logic                  AluEn,
  output logic [ALU_FUN_W-1:0]  AluFun,
  output logic                  ClkGateEn,
  output logic [DATA_W-1:0]     TxData,
  output logic                  TxWrEn,
  output logic                  CmdErr
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]     reg_wr_data_q, reg_wr_data_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic [ALU_FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic                  clk_gate_q, clk_gate_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_wr_en_q, tx_wr_en_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  resp_alu_q, resp_alu_d;
  logic                  alu_pend_q, alu_pend_d;
  logic                  tmr_clr;
  logic                  tmr_en;
  logic                  tmr_tc;

  ctrl_wait_timer #(
    .MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk    (CLK),
    .rst    (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .ld     (1'b0),
    .ld_val ('0),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    reg_wr_en_d   = 1'b0;
    reg_rd_en_d   = 1'b0;
    alu_en_d      = 1'b0;
    alu_fun_d     = alu_fun_q;
    clk_gate_d    = clk_gate_q;
    tx_data_d     = tx_data_q;
    tx_wr_en_d    = 1'b0;
    cmd_err_d     = 1'b0;
    result_d      = result_q;
    resp_alu_d    = resp_alu_q;
    alu_pend_d    = alu_pend_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RxValid) begin
          case (RxData)
            DATA_W'(OP_WR):      state_d = S_WR_ADDR;
            DATA_W'(OP_RD):      state_d = S_RD_ADDR;
            DATA_W'(OP_ALU):     state_d = S_OPA;
            DATA_W'(OP_ALU_RUN): state_d = S_ALU_FUN;
            default:             cmd_err_d = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (RxValid) begin
          reg_addr_d = RxData[ADDR_W-1:0];
          state_d    = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RxValid) begin
          reg_wr_data_d = RxData;
          reg_wr_en_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RxValid) begin
          reg_addr_d  = RxData[ADDR_W-1:0];
          reg_rd_en_d = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        tmr_en    = 1'b1;
        cmd_err_d = RxValid;
        if (RegRdValid) begin
          result_d   = {{DATA_W{1'b0}}, RegRdData};
          tx_data_d  = RegRdData;
          resp_alu_d = 1'b0;
          state_d    = S_TX_LO;
        end else if (tmr_tc) begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_OPA, S_OPB: begin
        if (RxValid) begin
          reg_addr_d    = (state_q == S_OPA) ? ADDR_W'(REG_OPA) : ADDR_W'(REG_OPB);
          reg_wr_data_d = RxData;
          reg_wr_en_d   = 1'b1;
          state_d       = (state_q == S_OPA) ? S_OPB : S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        // The gate opens one cycle ahead of the start strobe so the ALU clock is running.
        if (alu_pend_q) begin
          cmd_err_d  = RxValid;
          alu_en_d   = 1'b1;
          alu_pend_d = 1'b0;
          tmr_clr    = 1'b1;
          state_d    = S_ALU_WAIT;
        end else if (RxValid) begin
          alu_fun_d  = RxData[ALU_FUN_W-1:0];
          clk_gate_d = 1'b1;
          alu_pend_d = 1'b1;
        end
      end
      S_ALU_WAIT: begin
        tmr_en    = 1'b1;
        cmd_err_d = RxValid;
        if (AluValid) begin
          result_d   = AluOut;
          tx_data_d  = AluOut[DATA_W-1:0];
          resp_alu_d = 1'b1;
          clk_gate_d = 1'b0;
          state_d    = S_TX_LO;
        end else if (tmr_tc) begin
          cmd_err_d  = 1'b1;
          clk_gate_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_TX_LO: begin
        cmd_err_d = RxValid;
        if (!FifoFull) begin
          tx_wr_en_d = 1'b1;
          state_d    = resp_alu_q ? S_TX_HI : S_IDLE;
        end
      end
      S_TX_HI: begin
        // Data and push move together, so the low byte stays on TxData while held.
        cmd_err_d = RxValid;
        if (!FifoFull) begin
          tx_data_d  = result_q[2*DATA_W-1:DATA_W];
          tx_wr_en_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_wr_en_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      result_q      <= '0;
      resp_alu_q    <= 1'b0;
      alu_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_en_q   <= reg_rd_en_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_q    <= clk_gate_d;
      tx_data_q     <= tx_data_d;
      tx_wr_en_q    <= tx_wr_en_d;
      cmd_err_q     <= cmd_err_d;
      result_q      <= result_d;
      resp_alu_q    <= resp_alu_d;
      alu_pend_q    <= alu_pend_d;
    end
  end

  assign RegAddr   = reg_addr_q;
  assign RegWrData = reg_wr_data_q;
  assign RegWrEn   = reg_wr_en_q;
  assign RegRdEn   = reg_rd_en_q;
  assign AluEn     = alu_en_q;
  assign AluFun    = alu_fun_q;
  assign ClkGateEn = clk_gate_q;
  assign TxData    = tx_data_q;
  assign TxWrEn    = tx_wr_en_q;
  assign CmdErr    = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb/tb_rx_cmd_ctrl.sv - randomized self-checking bench for rx_cmd_ctrl
module tb_rx_cmd_ctrl;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int WAIT_MAX = 15;

  logic        CLK;
  logic        RST;
  logic [7:0]  RxData;
  logic        RxValid;
  logic [7:0]  RegRdData;
  logic        RegRdValid;
  logic [15:0] AluOut;
  logic        AluValid;
  logic        FifoFull;
  logic [3:0]  RegAddr;
  logic [7:0]  RegWrData;
  logic        RegWrEn;
  logic        RegRdEn;
  logic        AluEn;
  logic [3:0]  AluFun;
  logic        ClkGateEn;
  logic [7:0]  TxData;
  logic        TxWrEn;
  logic        CmdErr;

  rx_cmd_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLK(CLK), .RST(RST), .RxData(RxData), .RxValid(RxValid),
    .RegRdData(RegRdData), .RegRdValid(RegRdValid), .AluOut(AluOut),
    .AluValid(AluValid), .FifoFull(FifoFull), .RegAddr(RegAddr),
    .RegWrData(RegWrData), .RegWrEn(RegWrEn), .RegRdEn(RegRdEn),
    .AluEn(AluEn), .AluFun(AluFun), .ClkGateEn(ClkGateEn), .TxData(TxData),
    .TxWrEn(TxWrEn), .CmdErr(CmdErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] golden [16];
  logic [7:0] dut_regs [16];
  logic [7:0] exp_tx [$];
  logic [7:0] got_tx [$];
  int exp_wr = 0, exp_err = 0;
  int wr_cnt = 0, err_cnt = 0, rd_n = 0, alu_n = 0;
  int rd_lat = 0, alu_lat = 0, rd_cd = -1, alu_cd = -1;
  int cyc = 0, push_cyc = 0, alu_en_cyc = 0, err_cyc = 0;
  int gate_hi = 0, excl_viol = 0, full_viol = 0, gate_viol = 0;
  logic [3:0]  rd_addr;
  logic [15:0] alu_res;
  logic [3:0]  last_wr_addr;
  logic [7:0]  last_wr_data;
  logic        err_gate = 1'b0, gate_p1 = 1'b0, gate_p2 = 1'b0;
  bit          rand_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU the bench plays: plain arithmetic on the two operands.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      4'd5:    return {a, b};
      default: return {b, a ^ b};
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {2'b00, RegAddr, RegWrData, RegWrEn, RegRdEn, AluEn, AluFun,
            ClkGateEn, TxData, TxWrEn, CmdErr};
  endfunction

  // Monitor plus register-file / ALU responders, sampling 1 time unit after each edge.
  initial begin
    RegRdValid = 1'b0; RegRdData = '0; AluValid = 1'b0; AluOut = '0;
    for (int i = 0; i < 16; i++) dut_regs[i] = '0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if ((int'(RegWrEn) + int'(RegRdEn) + int'(AluEn) + int'(TxWrEn)) > 1) excl_viol++;
      if (TxWrEn && FifoFull) full_viol++;
      if (AluValid && ClkGateEn) gate_viol++;
      if (AluEn && !(ClkGateEn && gate_p1 && !gate_p2)) gate_viol++;
      if (ClkGateEn) gate_hi++;
      if (RegWrEn) begin
        dut_regs[RegAddr] = RegWrData;
        last_wr_addr = RegAddr; last_wr_data = RegWrData;
        wr_cnt++;
      end
      if (RegRdEn) begin rd_n++; rd_addr = RegAddr; rd_cd = rd_lat; end
      if (AluEn) begin
        alu_n++; alu_en_cyc = cyc; alu_cd = alu_lat;
        alu_res = alu_ref(dut_regs[0], dut_regs[1], AluFun);
      end
      if (TxWrEn) begin got_tx.push_back(TxData); push_cyc = cyc; end
      if (CmdErr) begin err_cnt++; err_cyc = cyc; err_gate = ClkGateEn; end
      gate_p2 = gate_p1; gate_p1 = ClkGateEn;
      RegRdValid = 1'b0; AluValid = 1'b0;
      if (rd_cd == 0) begin RegRdValid = 1'b1; RegRdData = dut_regs[rd_addr]; end
      if (rd_cd >= 0) rd_cd--;
      if (alu_cd == 0) begin AluValid = 1'b1; AluOut = alu_res; end
      if (alu_cd >= 0) alu_cd--;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK); RxData = b; RxValid = 1'b1;
    @(negedge CLK); RxValid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(got_tx.size() == exp_tx.size() && wr_cnt == exp_wr && err_cnt == exp_err) && n < 100) begin
      @(negedge CLK);
      if (rand_full) FifoFull = ($urandom_range(0, 3) == 0);
      n++;
    end
    FifoFull = 1'b0;
    repeat (3) @(negedge CLK);
    chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_wr"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, "_txn"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    while (got_tx.size() > 0 && exp_tx.size() > 0)
      chk({tag, "_tx"}, 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
    got_tx.delete(); exp_tx.delete();
    exp_err = err_cnt; exp_wr = wr_cnt;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int gap);
    send_byte(8'hAA, gap); send_byte({4'h0, a}, gap); send_byte(d, gap);
    golden[a] = d; exp_wr++;
    wait_done("wr");
    chk("wr_reg", 32'(dut_regs[a]), 32'(d));
  endtask

  task automatic do_read(input logic [3:0] a, input int lat, input int gap);
    rd_lat = lat;
    send_byte(8'hBB, gap); send_byte({4'h0, a}, gap);
    exp_tx.push_back(golden[a]);
    wait_done("rd");
  endtask

  task automatic push_alu(input logic [3:0] f);
    logic [15:0] r;
    r = alu_ref(golden[0], golden[1], f);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic do_alu_cc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                           input int lat, input int gap);
    alu_lat = lat; gate_hi = 0;
    send_byte(8'hCC, gap); send_byte(a, gap); send_byte(b, gap); send_byte({4'h0, f}, gap);
    golden[0] = a; golden[1] = b; exp_wr += 2;
    push_alu(f);
    wait_done("alu_cc");
    chk("alu_cc_gate", 32'(gate_hi), 32'(lat + 2));
  endtask

  task automatic do_alu_dd(input logic [3:0] f, input int lat, input int gap);
    alu_lat = lat; gate_hi = 0;
    send_byte(8'hDD, gap); send_byte({4'h0, f}, gap);
    push_alu(f);
    wait_done("alu_dd");
    chk("alu_dd_gate", 32'(gate_hi), 32'(lat + 2));
  endtask

  initial begin
    int wr_before, rel_cyc, alu_before;
    RST = 1'b1; RxData = '0; RxValid = 1'b0; FifoFull = 1'b0;
    for (int i = 0; i < 16; i++) golden[i] = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", outs(), 32'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    do_write(4'h5, 8'h3C, 0);
    chk("wr_addr", 32'(last_wr_addr), 32'h5);
    chk("wr_data", 32'(last_wr_data), 32'h3C);
    do_read(4'h5, 3, 0);
    chk("rd_strobes", 32'(rd_n), 32'd1);
    alu_before = alu_n;
    do_alu_cc(8'h07, 8'h03, 4'h0, 4, 0);
    chk("alu_reg0", 32'(dut_regs[0]), 32'h07);
    chk("alu_reg1", 32'(dut_regs[1]), 32'h03);
    chk("alu_strobes", 32'(alu_n - alu_before), 32'd1);

    // Backpressure on a read response.
    FifoFull = 1'b1; rd_lat = 0;
    send_byte(8'hBB, 0); send_byte(8'h05, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i >= 3) chk("bp_data", 32'(TxData), 32'h3C);
    end
    chk("bp_nopush", 32'(got_tx.size()), 32'd0);
    rel_cyc = cyc;
    FifoFull = 1'b0;
    exp_tx.push_back(8'h3C);
    wait_done("bp");
    chk("bp_push_cyc", 32'(push_cyc), 32'(rel_cyc + 1));

    send_byte(8'h55, 0);
    exp_err++;
    wait_done("bad_op");

    // Read valid on the last waiting cycle wins; one cycle later times out.
    do_read(4'h5, WAIT_MAX, 0);
    rd_lat = WAIT_MAX + 1;
    send_byte(8'hBB, 0); send_byte(8'h05, 0);
    exp_err++;
    wait_done("rd_to");

    alu_lat = -1; gate_hi = 0;
    send_byte(8'hDD, 0); send_byte(8'h01, 0);
    exp_err++;
    wait_done("alu_to");
    chk("alu_to_dist", 32'(err_cyc - alu_en_cyc), 32'(WAIT_MAX + 1));
    chk("alu_to_gate", 32'(err_gate), 32'd0);
    chk("alu_to_gate_cnt", 32'(gate_hi), 32'(WAIT_MAX + 2));

    // A byte landing while the read is outstanding is dropped.
    rd_lat = 10;
    send_byte(8'hBB, 0); send_byte(8'h05, 0); send_byte(8'hAA, 0);
    exp_tx.push_back(golden[5]); exp_err++;
    wait_done("rd_drop");

    // Reset in WR_DATA aborts the write.
    wr_before = wr_cnt;
    send_byte(8'hAA, 0); send_byte(8'h05, 0);
    RxData = 8'h99; RxValid = 1'b1; RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_outs", outs(), 32'h0);
    RxValid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_no_wr", 32'(wr_cnt), 32'(wr_before));
    chk("rst_idle_outs", outs(), 32'h0);
    do_write(4'h6, 8'h77, 0);

    rand_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2));
        1: do_read(4'($urandom_range(0, 15)), $urandom_range(0, 12), $urandom_range(0, 2));
        2: do_alu_cc(8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)),
                     $urandom_range(0, 12), $urandom_range(0, 2));
        default: do_alu_dd(4'($urandom_range(0, 7)), $urandom_range(0, 12), $urandom_range(0, 2));
      endcase
    end
    rand_full = 1'b0;

    for (int i = 0; i < 16; i++) chk("regfile", 32'(dut_regs[i]), 32'(golden[i]));
    chk("strobe_excl", 32'(excl_viol), 32'd0);
    chk("full_push", 32'(full_viol), 32'd0);
    chk("gate_rules", 32'(gate_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
